// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter that lets NUM_REQ requesters share one
//               fifo write port, one burst per grant, with back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int c_grant_w = $clog2(NUM_REQ);
    localparam int c_cnt_w   = $clog2(MAX_BURST) + 1;
    localparam logic [c_cnt_w-1:0]   c_last_beat  = c_cnt_w'(MAX_BURST - 1);
    localparam logic [c_grant_w-1:0] c_grant_init = c_grant_w'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_grant_w-1:0] grant_q, grant_d;
    logic [c_grant_w-1:0] last_grant_q, last_grant_d;
    logic [c_cnt_w-1:0]   beat_cnt_q, beat_cnt_d;

    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
    logic                  arb_found;
    logic [c_grant_w-1:0]  arb_pick;
    logic [c_grant_w-1:0]  arb_cand;
    logic                  owner_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_cand = c_grant_w'((int'(last_grant_q) + k) % NUM_REQ);
            if (!arb_found && req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_pick  = arb_cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        fifo_wen     = 1'b0;
        fifo_data    = '0;
        owner_valid  = req_valid[grant_q];
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d    = arb_pick;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!owner_valid) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else if (!fifo_full) begin
                    req_ready[grant_q] = 1'b1;
                    fifo_wen           = 1'b1;
                    fifo_data          = req_data_arr[grant_q];
                    beat_cnt_d         = beat_cnt_q + 1'b1;
                    // A last beat that is also the forced-rotation beat releases once.
                    if (req_last[grant_q] || (beat_cnt_q == c_last_beat)) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q == ST_BURST);
    assign grant_id = grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= c_grant_init;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter (vectors, directed
//               sequences and randomized traffic against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wen;
    logic [DW-1:0]   fifo_data;
    logic [1:0]      grant_id;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers following the arbitration rules.
    int m_busy, m_owner, m_last, m_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wen(fifo_wen), .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         full;
        logic [N-1:0] exp_ready;
        logic         exp_busy;
        logic [1:0]   exp_grant;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        req_data  = '0;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wen", fifo_wen, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_data", fifo_data, 0);
        @(negedge clk);
        reset   = 1'b0;
        m_busy  = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    task automatic rand_cycle();
        logic [N-1:0]  er;
        logic          ew;
        logic [DW-1:0] ed;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(0, 3) != 0);
            req_last[i]  = ($urandom_range(0, 4) == 0);
        end
        fifo_full = ($urandom_range(0, 4) == 0);
        req_data  = {$urandom, $urandom};
        #1;
        er = '0;
        if (m_busy != 0 && req_valid[m_owner] && !fifo_full) er[m_owner] = 1'b1;
        ew = |er;
        ed = ew ? req_data[m_owner*DW +: DW] : '0;
        chk("rnd_busy", busy, m_busy);
        chk("rnd_ready", req_ready, er);
        chk("rnd_wen", fifo_wen, ew);
        chk("rnd_data", fifo_data, ed);
        if (m_busy != 0) chk("rnd_grant", grant_id, m_owner);
        if (fifo_full) chk("rnd_wen_when_full", fifo_wen, 0);
        // Advance the model by one clock.
        if (m_busy == 0) begin
            for (int k = 1; k <= N; k++) begin
                if (req_valid[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_busy  = 1;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_last = m_owner;
            m_busy = 0;
        end else if (!fifo_full) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_last = m_owner;
                m_busy = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int bc[N];
        int writes;

        tbl[0]  = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[3]  = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[4]  = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[5]  = '{4'b1100, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{4'b1100, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[7]  = '{4'b1100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[8]  = '{4'b1100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[9]  = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

        // Owner drop, last-beat release and a stall, from a fresh reset.
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].valid;
            req_last  = tbl[i].last;
            fifo_full = tbl[i].full;
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].exp_ready);
            chk($sformatf("vec%0d_wen", i), fifo_wen, |tbl[i].exp_ready);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("vec%0d_data", i), fifo_data,
                (|tbl[i].exp_ready) ? (8'hA0 + 8'(tbl[i].exp_grant)) : 8'h00);
            if (tbl[i].exp_busy) chk($sformatf("vec%0d_grant", i), grant_id, tbl[i].exp_grant);
            @(negedge clk);
        end

        // All requesters valid: four full bursts in round-robin order, then wrap.
        do_reset();
        for (int i = 0; i < N; i++) bc[i] = 0;
        req_valid = '1;
        for (int b = 0; b < 5; b++) begin
            #1;
            chk("rr_idle_busy", busy, 0);
            @(negedge clk);
            for (int t = 0; t < MB; t++) begin
                for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i * 16 + bc[i]);
                #1;
                chk("rr_grant", grant_id, b % N);
                chk("rr_wen", fifo_wen, 1);
                chk("rr_data", fifo_data, (b % N) * 16 + bc[b % N]);
                bc[b % N]++;
                @(negedge clk);
            end
        end

        // fifo_full stalls a burst for three cycles without losing a beat.
        do_reset();
        req_valid = 4'b0010;
        writes    = 0;
        #1;
        chk("full_idle", busy, 0);
        @(negedge clk);
        for (int t = 0; t < 7; t++) begin
            fifo_full = (t >= 2 && t <= 4);
            req_data[1*DW +: DW] = DW'(8'h10 + writes);
            #1;
            chk("full_busy", busy, 1);
            chk("full_grant", grant_id, 1);
            chk("full_wen", fifo_wen, !fifo_full);
            chk("full_ready", req_ready, fifo_full ? 4'b0000 : 4'b0010);
            if (fifo_wen) begin
                chk("full_data", fifo_data, 8'h10 + writes);
                writes++;
            end
            @(negedge clk);
        end
        fifo_full = 1'b0;
        #1;
        chk("full_release", busy, 0);
        chk("full_total", writes, MB);
        @(negedge clk);

        // Reset asserted during the third beat drops the write immediately.
        do_reset();
        req_valid = 4'b0011;
        req_data  = {8'h00, 8'h00, 8'hB1, 8'hB0};
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstmid_wen_before", fifo_wen, 1);
        reset = 1'b1;
        #1;
        chk("rstmid_wen", fifo_wen, 0);
        chk("rstmid_ready", req_ready, 0);
        chk("rstmid_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_idle", busy, 0);
        @(negedge clk);
        #1;
        chk("rstmid_grant", grant_id, 0);
        chk("rstmid_regrant_data", fifo_data, 8'hB0);
        @(negedge clk);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) rand_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
